// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types and constants for the 7-segment scan controller
package seg7_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_COMMIT
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_MINUS = 8'hBF;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble converter, one input bit per clock
module bin2bcd_seq #(
    parameter int W  = 16,
    parameter int ND = 5
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [W-1:0]    bin_i,
    output logic            done_o,
    output logic [4*ND-1:0] bcd_o
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    logic [W-1:0]    bin_q;
    logic [4*ND-1:0] bcd_q, bcd_d;
    logic [CW-1:0]   cnt_q;
    logic            run_q;

    always_comb begin
        bcd_d = bcd_q;
        for (int k = 0; k < ND; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) begin
                bcd_d[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            end
        end
    end

    // Bits carried out above the top nibble are dropped; callers flag overflow separately.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start_i) begin
            bin_q <= bin_i;
            bcd_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b1;
        end else if (run_q) begin
            bcd_q <= {bcd_d[4*ND-2:0], bin_q[W-1]};
            bin_q <= {bin_q[W-2:0], 1'b0};
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(W - 1)) begin
                run_q <= 1'b0;
            end
        end
    end

    assign done_o = run_q && (cnt_q == CW'(W - 1));
    assign bcd_o  = bcd_q;
endmodule

// File: rtl/dec2seg7.sv
// rtl/dec2seg7.sv - BCD digit to active-low segment pattern (bit7 = DP, bit6 = g)
module dec2seg7
    import seg7_pkg::*;
(
    input  bcd_t       digit_i,
    input  logic       en_i,
    output logic [7:0] seg_o
);
    always_comb begin
        seg_o = SEG_BLANK;
        if (en_i) begin
            case (digit_i)
                4'd0:    seg_o = 8'hC0;
                4'd1:    seg_o = 8'hF9;
                4'd2:    seg_o = 8'hA4;
                4'd3:    seg_o = 8'hB0;
                4'd4:    seg_o = 8'h99;
                4'd5:    seg_o = 8'h92;
                4'd6:    seg_o = 8'h82;
                4'd7:    seg_o = 8'hF8;
                4'd8:    seg_o = 8'h80;
                4'd9:    seg_o = 8'h90;
                default: seg_o = SEG_BLANK;
            endcase
        end
    end
endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - signed sample to multiplexed common-anode 7-segment display
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int W           = 16,
    parameter int NDIG        = 6,
    parameter int REFRESH_DIV = 50000
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [W-1:0]    DATA,
    input  logic            LOAD,
    output logic            BUSY,
    output logic            OVF,
    output logic [NDIG-1:0] AN,
    output logic [7:0]      SEG
);
    localparam int NM = NDIG - 1;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [63:0] OVF_LIMIT = pow10(NM);

    state_t          state_q;
    logic            busy_q, ovf_q, neg_q, neg_n_q, ovf_n_q;
    logic [4*NM-1:0] disp_q;
    logic [NM-1:0]   blank_q, blank_d;
    logic [W-1:0]    mag_d;
    logic            ovf_d, conv_start, conv_done, zero_above;
    logic [4*NM-1:0] conv_bcd;

    logic [RW-1:0]   rcnt_q;
    logic [IW-1:0]   idx_q;
    logic [NDIG-1:0] an_q;
    logic [7:0]      seg_q, seg_d, dec_seg;
    bcd_t            cur_dig;
    logic            cur_en;

    // Unsigned W-bit negate so the most negative sample maps to 2^(W-1).
    assign mag_d      = DATA[W-1] ? -DATA : DATA;
    assign ovf_d      = 64'(mag_d) >= OVF_LIMIT;
    assign conv_start = (state_q == ST_IDLE) && LOAD;

    bin2bcd_seq #(
        .W  (W),
        .ND (NM)
    ) u_conv (
        .clk_i   (CLK),
        .rst_i   (RST),
        .start_i (conv_start),
        .bin_i   (mag_d),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd)
    );

    always_comb begin
        blank_d    = '0;
        zero_above = 1'b1;
        for (int k = NM - 1; k >= 1; k--) begin
            zero_above = zero_above && (conv_bcd[4*k +: 4] == 4'd0);
            blank_d[k] = zero_above;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            neg_q   <= 1'b0;
            neg_n_q <= 1'b0;
            ovf_n_q <= 1'b0;
            disp_q  <= '0;
            blank_q <= ~(NM'(1));
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (LOAD) begin
                        neg_n_q <= DATA[W-1];
                        ovf_n_q <= ovf_d;
                        busy_q  <= 1'b1;
                        state_q <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    if (conv_done) begin
                        state_q <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    disp_q  <= conv_bcd;
                    neg_q   <= neg_n_q;
                    ovf_q   <= ovf_n_q;
                    blank_q <= blank_d;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cur_dig = '0;
        cur_en  = 1'b0;
        for (int k = 0; k < NM; k++) begin
            if (idx_q == IW'(k)) begin
                cur_dig = disp_q[4*k +: 4];
                cur_en  = ~blank_q[k];
            end
        end
    end

    dec2seg7 u_dec (
        .digit_i (cur_dig),
        .en_i    (cur_en),
        .seg_o   (dec_seg)
    );

    always_comb begin
        seg_d = dec_seg;
        if (ovf_q) begin
            seg_d = SEG_MINUS;
        end else if (idx_q == IW'(NM)) begin
            seg_d = neg_q ? SEG_MINUS : SEG_BLANK;
        end
    end

    // Scan free-runs; AN and SEG are registered from the same index so they switch together.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rcnt_q <= '0;
            idx_q  <= '0;
            an_q   <= '1;
            seg_q  <= SEG_BLANK;
        end else begin
            if (rcnt_q == RW'(REFRESH_DIV - 1)) begin
                rcnt_q <= '0;
                idx_q  <= (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + IW'(1);
            end else begin
                rcnt_q <= rcnt_q + RW'(1);
            end
            an_q  <= ~(NDIG'(1) << idx_q);
            seg_q <= seg_d;
        end
    end

    assign BUSY = busy_q;
    assign OVF  = ovf_q;
    assign AN   = an_q;
    assign SEG  = seg_q;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - scoreboard bench for seg7_scan_ctrl at NDIG=6 and NDIG=4
module tb_seg7_scan_ctrl;
    localparam int W    = 16;
    localparam int RDIV = 4;
    localparam logic [7:0] SEG_TBL [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                            8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    logic clk = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   done_w [2];

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected display: bit 48 = OVF, byte k = SEG shown while digit k is selected.
    function automatic logic [48:0] model(input int v, input int nd);
        int mag, p;
        bit ov;
        logic [48:0] r;
        mag = (v < 0) ? -v : v;
        p = 1;
        for (int k = 0; k < nd - 1; k++) p = p * 10;
        ov = (mag >= p);
        r = '1;
        r[48] = ov;
        p = 1;
        for (int k = 0; k < nd - 1; k++) begin
            if (ov)                      r[8*k +: 8] = 8'hBF;
            else if (k == 0 || mag >= p) r[8*k +: 8] = SEG_TBL[(mag / p) % 10];
            else                         r[8*k +: 8] = 8'hFF;
            p = p * 10;
        end
        r[8*(nd-1) +: 8] = (ov || v < 0) ? 8'hBF : 8'hFF;
        return r;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int ND = (g == 0) ? 6 : 4;

        logic          rst  = 1'b1;
        logic          load = 1'b0;
        logic [W-1:0]  data = '0;
        logic          busy, ovf;
        logic [ND-1:0] an;
        logic [7:0]    seg;
        logic [48:0]   exp_q [$];
        logic [48:0]   cur_exp;
        logic          rst_smp = 1'b0;
        int            edge_n  = 0;
        int            free_at = 0;
        int            busy_run = 0;
        int            an_run = 0;
        int            an_prev = -1;
        bit            busy_prev = 1'b0;

        seg7_scan_ctrl #(
            .W           (W),
            .NDIG        (ND),
            .REFRESH_DIV (RDIV)
        ) dut (
            .CLK  (clk),
            .RST  (rst),
            .DATA (data),
            .LOAD (load),
            .BUSY (busy),
            .OVF  (ovf),
            .AN   (an),
            .SEG  (seg)
        );

        always @(posedge clk) rst_smp <= rst;

        task automatic step(input int n);
            repeat (n) begin
                @(posedge clk);
                #1;
                edge_n++;
            end
        endtask

        task automatic do_reset();
            rst = 1'b1;
            step(1);
            rst = 1'b0;
            free_at = edge_n + 1;
            exp_q.delete();
        endtask

        // A load is taken only if the converter is idle at that edge.
        task automatic do_load(input int v);
            data = W'(v);
            load = 1'b1;
            step(1);
            load = 1'b0;
            if (edge_n >= free_at) begin
                exp_q.push_back(model(v, ND));
                free_at = edge_n + W + 2;
            end
        endtask

        always @(negedge clk) begin
            int idx;
            bit fall;
            if (rst_smp) begin
                chk($sformatf("i%0d rst_busy", g), busy, 0);
                chk($sformatf("i%0d rst_ovf", g), ovf, 0);
                chk($sformatf("i%0d rst_an", g), an, {ND{1'b1}});
                chk($sformatf("i%0d rst_seg", g), seg, 8'hFF);
                cur_exp   = model(0, ND);
                busy_prev = 1'b0;
                busy_run  = 0;
                an_prev   = -1;
                an_run    = 0;
            end else begin
                idx = -1;
                for (int k = 0; k < ND; k++) begin
                    if (an == ~(ND'(1) << k)) idx = k;
                end
                if (an !== {ND{1'b1}}) begin
                    chk($sformatf("i%0d an_onecold", g), idx >= 0, 1);
                end
                if (idx >= 0) begin
                    chk($sformatf("i%0d seg_d%0d", g, idx), seg, cur_exp[8*idx +: 8]);
                    if (idx != an_prev) begin
                        if (an_prev >= 0) begin
                            chk($sformatf("i%0d an_order", g), idx, (an_prev + 1) % ND);
                            chk($sformatf("i%0d an_dwell", g), an_run, RDIV);
                        end
                        an_prev = idx;
                        an_run  = 1;
                    end else begin
                        an_run++;
                    end
                end
                fall = busy_prev && !busy;
                if (busy) busy_run++;
                if (fall) begin
                    chk($sformatf("i%0d busy_len", g), busy_run, W + 1);
                    chk($sformatf("i%0d commit_expected", g), exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) cur_exp = exp_q.pop_front();
                    busy_run = 0;
                end
                chk($sformatf("i%0d ovf", g), ovf, cur_exp[48]);
                busy_prev = busy;
            end
        end

        initial begin
            logic signed [W-1:0] s;
            do_reset();
            step(3);
            if (g == 0) begin
                do_load(1234);   step(50);
                do_load(-7);     step(50);
                do_load(-32768); step(50);
                do_load(1234);   step(50);
                do_load(0);      step(5);
                do_load(99);     step(50);
                do_load(4321);   step(4);
                do_reset();      step(50);
                for (int i = 0; i < 40; i++) begin
                    s = W'($urandom);
                    do_load(int'(s));
                    step($urandom_range(0, 45));
                end
            end else begin
                do_load(1000);   step(50);
                do_load(999);    step(50);
                do_load(-1000);  step(50);
                do_load(-999);   step(50);
                for (int i = 0; i < 30; i++) begin
                    if (i % 2 == 0) s = W'(int'($urandom_range(0, 2000)) - 1000);
                    else            s = W'($urandom);
                    do_load(int'(s));
                    step($urandom_range(0, 45));
                end
            end
            step(50);
            chk($sformatf("i%0d queue_drained", g), exp_q.size(), 0);
            done_w[g] = 1'b1;
        end
    end

    initial begin
        int t;
        t = 0;
        while (!(done_w[0] && done_w[1]) && t < 50000) begin
            @(posedge clk);
            t++;
        end
        if (t >= 50000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: got %0d cycles expected completion", t);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
